// File: rtl/dircc_node_dual_port_mem.sv
// Dual-port byte-addressable memory with mixed port widths (port B is a narrower view of port A),
// Avalon-MM style slave handshakes and an optional power-up clear sweep.
module dircc_node_dual_port_mem #(
    parameter int unsigned DATA_WIDTH_A   = 32,
    parameter int unsigned WIDTH_RATIO    = 2,
    parameter int unsigned DEPTH_A        = 10240,
    parameter int unsigned ADDR_WIDTH_A   = 14,
    parameter int unsigned OUT_REG        = 0,
    parameter int unsigned CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH_A-1:0] CLEAR_VALUE = '0
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        reset_req,

    input  logic [ADDR_WIDTH_A-1:0]                     address,
    input  logic [DATA_WIDTH_A/8-1:0]                   byteenable,
    input  logic                                        chipselect,
    input  logic                                        read,
    input  logic                                        write,
    input  logic [DATA_WIDTH_A-1:0]                     writedata,
    output logic [DATA_WIDTH_A-1:0]                     readdata,
    output logic                                        readdatavalid,
    output logic                                        waitrequest,

    input  logic [ADDR_WIDTH_A+$clog2(WIDTH_RATIO)-1:0] address2,
    input  logic [DATA_WIDTH_A/WIDTH_RATIO/8-1:0]       byteenable2,
    input  logic                                        chipselect2,
    input  logic                                        read2,
    input  logic                                        write2,
    input  logic [DATA_WIDTH_A/WIDTH_RATIO-1:0]         writedata2,
    output logic [DATA_WIDTH_A/WIDTH_RATIO-1:0]         readdata2,
    output logic                                        readdatavalid2,
    output logic                                        waitrequest2
);

    localparam int unsigned DATA_WIDTH_B = DATA_WIDTH_A / WIDTH_RATIO;
    localparam int unsigned BYTES_A      = DATA_WIDTH_A / 8;
    localparam int unsigned BYTES_B      = DATA_WIDTH_B / 8;
    localparam int unsigned DEPTH_B      = DEPTH_A * WIDTH_RATIO;
    localparam int unsigned MEM_BYTES    = DEPTH_A * BYTES_A;
    localparam int unsigned IDX_W        = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [7:0] mem [MEM_BYTES];

    logic [0:0]              state_q, state_d;
    logic [ADDR_WIDTH_A-1:0] cnt_q, cnt_d;
    logic                    clear_en;

    logic        wait_c;
    logic        acc_a, wr_a, rd_a;
    logic        acc_b, wr_b, rd_b;
    logic        in_a, in_b;
    logic [31:0] base_a, base_b, base_clr;

    logic [DATA_WIDTH_A-1:0] rdw_a, rd1_a;
    logic [DATA_WIDTH_B-1:0] rdw_b, rd1_b;
    logic                    rv1_a, rv1_b;

    // Handshake: both ports stall together while resetting, draining or clearing.
    assign wait_c       = reset | reset_req | (state_q == ST_CLEAR);
    assign waitrequest  = wait_c;
    assign waitrequest2 = wait_c;

    // A simultaneous read+write request is a write.
    assign acc_a = chipselect & (read | write) & ~wait_c;
    assign wr_a  = acc_a & write;
    assign rd_a  = acc_a & ~write;

    assign acc_b = chipselect2 & (read2 | write2) & ~wait_c;
    assign wr_b  = acc_b & write2;
    assign rd_b  = acc_b & ~write2;

    // Port B word j starts at byte j*BYTES_B, which lands inside port A word j/WIDTH_RATIO.
    assign in_a     = 32'(address) < DEPTH_A;
    assign in_b     = 32'(address2) < DEPTH_B;
    assign base_a   = 32'(address) * BYTES_A;
    assign base_b   = 32'(address2) * BYTES_B;
    assign base_clr = 32'(cnt_q) * BYTES_A;

    // Clear sweep controller.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clear_en = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clear_en = ~reset;
                if (cnt_q == ADDR_WIDTH_A'(DEPTH_A - 1)) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH_A'(1);
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_READY;
                cnt_d   = '0;
            end
        endcase
    end

    // Storage update; port A is applied last so it wins on a shared byte.
    always_ff @(posedge clk) begin
        if (clear_en) begin
            for (int k = 0; k < BYTES_A; k++) begin
                mem[IDX_W'(base_clr + 32'(k))] <= CLEAR_VALUE[8*k +: 8];
            end
        end else begin
            if (wr_b && in_b) begin
                for (int k = 0; k < BYTES_B; k++) begin
                    if (byteenable2[k]) begin
                        mem[IDX_W'(base_b + 32'(k))] <= writedata2[8*k +: 8];
                    end
                end
            end
            if (wr_a && in_a) begin
                for (int k = 0; k < BYTES_A; k++) begin
                    if (byteenable[k]) begin
                        mem[IDX_W'(base_a + 32'(k))] <= writedata[8*k +: 8];
                    end
                end
            end
        end
    end

    // Read words are taken before this edge's writes land, so collisions return old data.
    always_comb begin
        rdw_a = '0;
        if (in_a) begin
            for (int k = 0; k < BYTES_A; k++) begin
                rdw_a[8*k +: 8] = mem[IDX_W'(base_a + 32'(k))];
            end
        end
    end

    always_comb begin
        rdw_b = '0;
        if (in_b) begin
            for (int k = 0; k < BYTES_B; k++) begin
                rdw_b[8*k +: 8] = mem[IDX_W'(base_b + 32'(k))];
            end
        end
    end

    // First read stage; data holds between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            rv1_a <= 1'b0;
            rv1_b <= 1'b0;
            rd1_a <= '0;
            rd1_b <= '0;
        end else begin
            rv1_a <= rd_a;
            rv1_b <= rd_b;
            if (rd_a) begin
                rd1_a <= rdw_a;
            end
            if (rd_b) begin
                rd1_b <= rdw_b;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH_A-1:0] rd2_a;
            logic [DATA_WIDTH_B-1:0] rd2_b;
            logic                    rv2_a, rv2_b;

            // Optional output stage, same hold behaviour as the first stage.
            always_ff @(posedge clk) begin
                if (reset) begin
                    rv2_a <= 1'b0;
                    rv2_b <= 1'b0;
                    rd2_a <= '0;
                    rd2_b <= '0;
                end else begin
                    rv2_a <= rv1_a;
                    rv2_b <= rv1_b;
                    if (rv1_a) begin
                        rd2_a <= rd1_a;
                    end
                    if (rv1_b) begin
                        rd2_b <= rd1_b;
                    end
                end
            end

            assign readdata       = rd2_a;
            assign readdatavalid  = rv2_a;
            assign readdata2      = rd2_b;
            assign readdatavalid2 = rv2_b;
        end else begin : g_no_out_reg
            assign readdata       = rd1_a;
            assign readdatavalid  = rv1_a;
            assign readdata2      = rd1_b;
            assign readdatavalid2 = rv1_b;
        end
    endgenerate

endmodule
